// File: rtl/sr_cmd_debouncer_pkg.sv
// Shared definitions for the set/reset command debouncer.
//   SYNC_STAGES     : depth of the per-button synchroniser
//   DEBOUNCE_SIM    : short stability window used in simulation
//   DEBOUNCE_BOARD  : stability window for the 100 MHz board build (10 ms)
//   sr_cmd_e        : encoding of the {S,R} command pair driven downstream
package sr_cmd_debouncer_pkg;

  localparam int SYNC_STAGES    = 2;
  localparam int DEBOUNCE_SIM   = 4;
  localparam int DEBOUNCE_BOARD = 1_000_000;

  // Bit 1 is S, bit 0 is R. CMD_INVALID is never issued by this block.
  typedef enum logic [1:0] {
    CMD_HOLD    = 2'b00,
    CMD_SET     = 2'b10,
    CMD_RST     = 2'b01,
    CMD_INVALID = 2'b11
  } sr_cmd_e;

endpackage

// File: rtl/sr_cmd_debouncer_if.sv
// Button/command bundle between the board (or bench) and the debouncer.
//   btn_set_raw, btn_rst_raw : raw asynchronous push-buttons
//   S, R                     : one-cycle set/reset command pulses
//   set_level, rst_level     : debounced button levels
//   conflict                 : one-cycle pulse when both buttons accept together
//   q_expect                 : modelled state of the downstream SR element
// master drives the buttons and observes the commands; slave is the debouncer.
interface sr_cmd_debouncer_if;

  logic btn_set_raw;
  logic btn_rst_raw;
  logic S;
  logic R;
  logic set_level;
  logic rst_level;
  logic conflict;
  logic q_expect;

  modport master (
    output btn_set_raw, btn_rst_raw,
    input  S, R, set_level, rst_level, conflict, q_expect
  );

  modport slave (
    input  btn_set_raw, btn_rst_raw,
    output S, R, set_level, rst_level, conflict, q_expect
  );

endinterface

// File: rtl/sr_cmd_debouncer_debounce_channel.sv
// One button channel: synchroniser, debounce counter, level register.
//   clk, rst : clock and synchronous active-high reset
//   raw      : asynchronous button input
//   level    : debounced level (registered)
//   rise     : high during the cycle whose closing edge takes level 0->1,
//              so a register clocked on that edge updates together with level
module debounce_channel
  import sr_cmd_debouncer_pkg::*;
#(
  parameter int STABLE_CYCLES = DEBOUNCE_SIM
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt;
  logic                   synced;
  logic                   accept;

  assign synced = sync[SYNC_STAGES-1];

  // The counter reaching STABLE_CYCLES is folded into "last count value seen
  // while still differing", so it never actually holds STABLE_CYCLES.
  assign accept = (synced != level) && (cnt == CNT_LAST);
  assign rise   = accept && !level;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
      if (synced == level) begin
        cnt <= '0;
      end else if (accept) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sr_cmd_debouncer.sv
// Command front end for the lab SR storage element.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of sr_cmd_debouncer_if (raw buttons in,
//              S/R pulses, debounced levels, conflict and q_expect out)
// Each button is debounced independently; a newly accepted press becomes a
// single S or R pulse. Simultaneous acceptance issues neither and flags
// conflict instead, so S=R=1 can never reach the SR element.
module sr_cmd_debouncer
  import sr_cmd_debouncer_pkg::*;
#(
  parameter int STABLE_CYCLES = DEBOUNCE_SIM
) (
  input  logic                 clk,
  input  logic                 rst,
  sr_cmd_debouncer_if.slave    bus
);

  logic    set_lvl, rst_lvl;
  logic    set_rise, rst_rise;
  sr_cmd_e cmd_next;
  logic    conflict_next;
  logic    s_q, r_q, conflict_q, q_q;

  debounce_channel #(.STABLE_CYCLES(STABLE_CYCLES)) u_set (
    .clk   (clk),
    .rst   (rst),
    .raw   (bus.btn_set_raw),
    .level (set_lvl),
    .rise  (set_rise)
  );

  debounce_channel #(.STABLE_CYCLES(STABLE_CYCLES)) u_rst (
    .clk   (clk),
    .rst   (rst),
    .raw   (bus.btn_rst_raw),
    .level (rst_lvl),
    .rise  (rst_rise)
  );

  always_comb begin
    cmd_next      = CMD_HOLD;
    conflict_next = 1'b0;
    if (set_rise && rst_rise) begin
      conflict_next = 1'b1;
    end else if (set_rise) begin
      cmd_next = CMD_SET;
    end else if (rst_rise) begin
      cmd_next = CMD_RST;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      conflict_q <= 1'b0;
      q_q        <= 1'b0;
    end else begin
      s_q        <= cmd_next[1];
      r_q        <= cmd_next[0];
      conflict_q <= conflict_next;
      if (cmd_next == CMD_SET) begin
        q_q <= 1'b1;
      end else if (cmd_next == CMD_RST) begin
        q_q <= 1'b0;
      end
    end
  end

  assign bus.S         = s_q;
  assign bus.R         = r_q;
  assign bus.conflict  = conflict_q;
  assign bus.q_expect  = q_q;
  assign bus.set_level = set_lvl;
  assign bus.rst_level = rst_lvl;

endmodule

// File: tb/tb_sr_cmd_debouncer.sv
// Directed bench for sr_cmd_debouncer with STABLE_CYCLES = 4.
module tb_sr_cmd_debouncer;
  import sr_cmd_debouncer_pkg::*;

  localparam int N = DEBOUNCE_SIM;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sr_cmd_debouncer_if bus ();

  sr_cmd_debouncer #(.STABLE_CYCLES(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- bookkeeping ----------------
  int n_total = 0;
  int n_pass  = 0;
  int edge_n  = 0;
  int s_cnt = 0, r_cnt = 0, c_cnt = 0;
  int last_s_edge = -1, last_r_edge = -1, last_c_edge = -1;

  // {S, R, conflict, set_level, rst_level, q_expect}
  logic [5:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // A level flips once the last N synchronised samples (each seen two edges
  // after it was sampled raw) all disagree with it.
  logic set_hist[$];
  logic rst_hist[$];
  logic m_set_lvl = 1'b0, m_rst_lvl = 1'b0, m_q = 1'b0;

  function automatic bit window_differs(input logic h[$], input logic lvl);
    if (h.size() - 1 < N) return 1'b0;
    for (int i = 0; i < N; i++)
      if (h[h.size() - 2 - i] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin : model
    bit sr, rr;
    logic ms, mr, mc;
    edge_n++;
    if (rst) begin
      set_hist = '{1'b0, 1'b0};
      rst_hist = '{1'b0, 1'b0};
      m_set_lvl = 1'b0;
      m_rst_lvl = 1'b0;
      m_q = 1'b0;
      exp_q.push_back(6'b0);
    end else begin
      sr = window_differs(set_hist, m_set_lvl) && !m_set_lvl;
      rr = window_differs(rst_hist, m_rst_lvl) && !m_rst_lvl;
      if (window_differs(set_hist, m_set_lvl)) m_set_lvl = ~m_set_lvl;
      if (window_differs(rst_hist, m_rst_lvl)) m_rst_lvl = ~m_rst_lvl;
      ms = sr && !rr;
      mr = rr && !sr;
      mc = sr && rr;
      if (ms) m_q = 1'b1;
      if (mr) m_q = 1'b0;
      set_hist.push_back(bus.btn_set_raw);
      rst_hist.push_back(bus.btn_rst_raw);
      if (set_hist.size() > N + 3) void'(set_hist.pop_front());
      if (rst_hist.size() > N + 3) void'(rst_hist.pop_front());
      exp_q.push_back({ms, mr, mc, m_set_lvl, m_rst_lvl, m_q});
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin : compare
    logic [5:0] e, a;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = {bus.S, bus.R, bus.conflict, bus.set_level, bus.rst_level, bus.q_expect};
      n_total++;
      if (a == e) n_pass++;
      else $display("FAIL cycle_outputs edge %0d: got S,R,conf,sl,rl,q=%b expected %b",
                    edge_n, a, e);
      n_total++;
      if ({bus.S, bus.R} != CMD_INVALID && !(bus.conflict && (bus.S || bus.R))) n_pass++;
      else $display("FAIL invariant edge %0d: got S,R,conf=%b%b%b expected no overlap",
                    edge_n, bus.S, bus.R, bus.conflict);
      if (bus.S)        begin s_cnt++; last_s_edge = edge_n; end
      if (bus.R)        begin r_cnt++; last_r_edge = edge_n; end
      if (bus.conflict) begin c_cnt++; last_c_edge = edge_n; end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic s, input logic r);
    @(negedge clk);
    bus.btn_set_raw = s;
    bus.btn_rst_raw = r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  int s0, r0, c0, e1;
  logic [5:0] bounce;

  initial begin
    bus.btn_set_raw = 1'b0;
    bus.btn_rst_raw = 1'b0;

    // 1. reset with toggling inputs
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst = 1'b1;
      bus.btn_set_raw = i[0];
      bus.btn_rst_raw = ~i[0];
    end
    @(negedge clk);
    rst = 1'b0;
    bus.btn_set_raw = 1'b0;
    bus.btn_rst_raw = 1'b0;
    @(negedge clk);
    check("after_reset_outputs",
          {bus.S, bus.R, bus.conflict, bus.set_level, bus.rst_level, bus.q_expect}, 0);
    idle(8);

    // 2. clean set press
    s0 = s_cnt; r0 = r_cnt; c0 = c_cnt;
    drive(1, 0); e1 = edge_n + 1;
    idle(20);
    check("set_pulse_count", s_cnt - s0, 1);
    check("set_pulse_edge", last_s_edge, e1 + 5);
    check("set_q", bus.q_expect, 1);
    check("set_level_held", bus.set_level, 1);
    check("set_no_r_conf", (r_cnt - r0) + (c_cnt - c0), 0);
    drive(0, 0); idle(10);

    // 3. bouncing reset press
    r0 = r_cnt;
    bounce = 6'b101101;
    for (int i = 5; i >= 0; i--) begin
      drive(0, bounce[i]);
      if (i == 0) e1 = edge_n + 1;
    end
    idle(15);
    check("bounce_r_count", r_cnt - r0, 1);
    check("bounce_r_edge", last_r_edge, e1 + 5);
    check("bounce_q", bus.q_expect, 0);
    drive(0, 0); idle(10);

    // 4. simultaneous press from q=0 and from q=1
    s0 = s_cnt; r0 = r_cnt; c0 = c_cnt;
    drive(1, 1); e1 = edge_n + 1;
    idle(12);
    check("both_conf_count_q0", c_cnt - c0, 1);
    check("both_conf_edge_q0", last_c_edge, e1 + 5);
    check("both_no_sr_q0", (s_cnt - s0) + (r_cnt - r0), 0);
    check("both_q0", bus.q_expect, 0);
    drive(0, 0); idle(10);
    drive(1, 0); idle(12);
    drive(0, 0); idle(10);
    s0 = s_cnt; r0 = r_cnt; c0 = c_cnt;
    drive(1, 1); idle(12);
    check("both_conf_count_q1", c_cnt - c0, 1);
    check("both_no_sr_q1", (s_cnt - s0) + (r_cnt - r0), 0);
    check("both_q1", bus.q_expect, 1);
    drive(0, 0); idle(10);

    // 5. overlapping presses
    s0 = s_cnt; r0 = r_cnt; c0 = c_cnt;
    drive(1, 0); idle(9);
    check("overlap_q_set", bus.q_expect, 1);
    drive(1, 1); idle(12);
    check("overlap_s_count", s_cnt - s0, 1);
    check("overlap_r_count", r_cnt - r0, 1);
    check("overlap_no_conf", c_cnt - c0, 0);
    check("overlap_q_rst", bus.q_expect, 0);
    drive(0, 0); idle(10);
    s0 = s_cnt;
    drive(1, 0); idle(12);
    check("rearm_s_count", s_cnt - s0, 1);
    check("rearm_q", bus.q_expect, 1);
    drive(0, 0); idle(10);
    drive(0, 1); idle(12);
    drive(0, 0); idle(10);

    // 6. reset in the middle of debouncing a held set button
    s0 = s_cnt;
    drive(1, 0);
    idle(4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    e1 = edge_n + 1;
    check("midreset_no_early_pulse", s_cnt - s0, 0);
    idle(12);
    check("midreset_s_count", s_cnt - s0, 1);
    check("midreset_s_edge", last_s_edge, e1 + 5);
    check("midreset_q", bus.q_expect, 1);
    drive(0, 0); idle(5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
